// File: rtl/des_pkg.sv
// DES constants, bit-permutation helpers and FSM state type shared by the round engine.
// Tables hold FIPS 46-3 bit numbers (1 = MSB); helpers map them onto packed vectors.
package des_pkg;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [1:0] SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int unsigned E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int unsigned P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Indexed [box][row*16 + col], row = {b1,b6}, col = b2..b5 of the 6-bit group.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        for (int i = 0; i < 64; i++) ip_perm[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        for (int i = 0; i < 64; i++) fp_perm[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        for (int i = 0; i < 48; i++) e_perm[47-i] = x[32-E_T[i]];
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        for (int i = 0; i < 32; i++) p_perm[31-i] = x[32-P_T[i]];
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        for (int i = 0; i < 56; i++) pc1_perm[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        for (int i = 0; i < 48; i++) pc2_perm[47-i] = x[56-PC2_T[i]];
    endfunction

    // Decrypt walks the schedule backwards: round 0 is unrotated, round n undoes SHIFT[16-n].
    function automatic logic [1:0] key_shift(input logic [3:0] n, input logic dec);
        if (!dec)
            return SHIFT[n];
        else if (n == 4'd0)
            return 2'd0;
        else
            return SHIFT[4'd0 - n];
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt, input logic right);
        case ({right, amt})
            3'b001:  return {x[26:0], x[27]};
            3'b010:  return {x[25:0], x[27:26]};
            3'b101:  return {x[0], x[27:1]};
            3'b110:  return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_fround.sv
// One combinational DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
// Zero latency; no flow control.
module des_fround
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    logic [47:0] x;
    logic [31:0] s_out;
    logic [5:0]  six;

    always_comb begin
        x     = e_perm(r) ^ k;
        s_out = '0;
        six   = '0;
        for (int s = 0; s < 8; s++) begin
            six = x[47-6*s -: 6];
            s_out[31-4*s -: 4] = SBOX[s][{six[5], six[0], six[4:1]}];
        end
    end

    assign l_next = r;
    assign r_next = l ^ p_perm(s_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock.
// Latency 16/ROUNDS_PER_CYCLE + OUT_REG cycles; one job at a time, result held until out_ready.
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit OUT_REG          = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_block,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic        mode_q;
    logic [63:0] out_q;
    logic        live_q;

    logic [31:0] l_c [RPC+1];
    logic [31:0] r_c [RPC+1];
    logic [27:0] c_c [RPC+1];
    logic [27:0] d_c [RPC+1];

    assign l_c[0] = l_q;
    assign r_c[0] = r_q;
    assign c_c[0] = c_q;
    assign d_c[0] = d_q;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [3:0]  n;
        logic [1:0]  amt;
        logic [47:0] subkey;

        assign n        = cnt_q[3:0] + 4'(j);
        assign amt      = key_shift(n, mode_q);
        assign c_c[j+1] = rot28(c_c[j], amt, mode_q);
        assign d_c[j+1] = rot28(d_c[j], amt, mode_q);
        assign subkey   = pc2_perm({c_c[j+1], d_c[j+1]});

        des_fround u_fround (
            .l      (l_c[j]),
            .r      (r_c[j]),
            .k      (subkey),
            .l_next (l_c[j+1]),
            .r_next (r_c[j+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        {l_q, r_q} <= ip_perm(in_block);
                        {c_q, d_q} <= pc1_perm(in_key);
                        mode_q     <= in_decrypt;
                        cnt_q      <= '0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != 5'd16) begin
                        l_q   <= l_c[RPC];
                        r_q   <= r_c[RPC];
                        c_q   <= c_c[RPC];
                        d_q   <= d_c[RPC];
                        cnt_q <= cnt_q + 5'(RPC);
                        if (!OUT_REG && (cnt_q + 5'(RPC) == 5'd16))
                            state_q <= ST_DONE;
                    end else begin
                        // Extra RUN cycle with all rounds done: capture FP of the swapped halves.
                        out_q   <= fp_perm({r_q, l_q});
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = live_q && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_block = out_valid ? (OUT_REG ? out_q : fp_perm({r_q, l_q})) : 64'd0;

endmodule

// File: tb/tb_des_round_engine.sv
// Randomized self-checking bench for des_round_engine against an array-based DES model.
module tb_des_round_engine;
    import des_pkg::*;

    localparam int RPC = 1;
    localparam bit OREG = 1'b1;
    localparam int LAT = 16 / RPC + (OREG ? 1 : 0);

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [63:0] in_block, in_key, out_block;

    logic        aux_vld, aux_dec;
    logic [63:0] aux_blk, aux_key;
    logic        aux_rdy [4];
    logic        aux_ov  [4];
    logic        aux_busy[4];
    logic [63:0] aux_ob  [4];

    int n_chk = 0;
    int n_fail = 0;

    des_round_engine #(.ROUNDS_PER_CYCLE(RPC), .OUT_REG(OREG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_block(in_block), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_aux
        des_round_engine #(.ROUNDS_PER_CYCLE(2 << g), .OUT_REG(1'(g % 2))) u_aux (
            .clk(clk), .rst_n(rst_n), .in_valid(aux_vld), .in_ready(aux_rdy[g]),
            .in_decrypt(aux_dec), .in_block(aux_blk), .in_key(aux_key),
            .out_valid(aux_ov[g]), .out_ready(1'b1), .out_block(aux_ob[g]), .busy(aux_busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit arrays in FIPS numbering (index 0 = bit 1), all 16 subkeys built up front.
    function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        bit m[64], kb[64], lr[64], cd[56], rc[56], pre[64];
        bit l[32], r[32], sv[32], fo[32], er[48];
        bit ks[16][48];
        bit t;
        int sh, row, col, kk;
        logic [3:0] v;
        logic [63:0] res;
        for (int i = 0; i < 64; i++) begin m[i] = blk[63-i]; kb[i] = key[63-i]; end
        for (int i = 0; i < 64; i++) lr[i] = m[IP_T[i]-1];
        for (int i = 0; i < 32; i++) begin l[i] = lr[i]; r[i] = lr[32+i]; end
        for (int i = 0; i < 56; i++) cd[i] = kb[PC1_T[i]-1];
        sh = 0;
        for (int n = 0; n < 16; n++) begin
            sh += int'(SHIFT[n]);
            for (int i = 0; i < 28; i++) begin
                rc[i]    = cd[(i + sh) % 28];
                rc[28+i] = cd[28 + (i + sh) % 28];
            end
            for (int j = 0; j < 48; j++) ks[n][j] = rc[PC2_T[j]-1];
        end
        for (int n = 0; n < 16; n++) begin
            kk = dec ? 15 - n : n;
            for (int j = 0; j < 48; j++) er[j] = r[E_T[j]-1] ^ ks[kk][j];
            for (int s = 0; s < 8; s++) begin
                row = 2 * int'(er[6*s]) + int'(er[6*s+5]);
                col = 8 * int'(er[6*s+1]) + 4 * int'(er[6*s+2]) + 2 * int'(er[6*s+3]) + int'(er[6*s+4]);
                v = SBOX[s][row*16 + col];
                for (int q = 0; q < 4; q++) sv[4*s+q] = v[3-q];
            end
            for (int j = 0; j < 32; j++) fo[j] = sv[P_T[j]-1];
            for (int j = 0; j < 32; j++) begin t = r[j]; r[j] = l[j] ^ fo[j]; l[j] = t; end
        end
        for (int i = 0; i < 32; i++) begin pre[i] = r[i]; pre[32+i] = l[i]; end
        for (int i = 0; i < 64; i++) res[63-i] = pre[FP_T[i]-1];
        return res;
    endfunction

    task automatic do_job(input logic [63:0] key, input logic [63:0] blk, input logic dec, input int hold);
        logic [63:0] exp, held;
        int g, lat;
        exp = ref_des(key, blk, dec);
        g = 0;
        while (in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        chk("ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_key = key; in_block = blk; in_decrypt = dec;
        @(negedge clk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            in_valid = 1'($urandom_range(0, 1));
            in_block = {$urandom, $urandom}; in_key = {$urandom, $urandom};
            in_decrypt = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        chk("latency", 64'(lat), 64'(LAT));
        chk("result", out_block, exp);
        held = out_block;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_block", out_block, held);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_out_block", out_block, 64'd0);
    endtask

    task automatic aux_kat(input logic [63:0] key, input logic [63:0] blk, input logic dec, input logic [63:0] exp);
        int lat[4];
        for (int g = 0; g < 4; g++) lat[g] = -1;
        @(negedge clk);
        aux_key = key; aux_blk = blk; aux_dec = dec; aux_vld = 1'b1;
        @(negedge clk);
        aux_vld = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (lat[g] < 0 && aux_ov[g] === 1'b1) begin
                    lat[g] = c;
                    chk($sformatf("aux%0d_result", g), aux_ob[g], exp);
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < 4; g++)
            chk($sformatf("aux%0d_latency", g), 64'(lat[g]), 64'(16 / (2 << g) + g % 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k1, p1, c1, z, c0, held;
        int lat;
        k1 = 64'h133457799BBCDFF1; p1 = 64'h0123456789ABCDEF; c1 = 64'h85E813540F0AB405;
        z = 64'd0; c0 = 64'h8CA64DE9C1B123A7;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_decrypt = 1'b0;
        in_block = '0; in_key = '0;
        aux_vld = 1'b0; aux_dec = 1'b0; aux_blk = '0; aux_key = '0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_block", out_block, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);

        chk("model_kat_enc", ref_des(k1, p1, 1'b0), c1);
        chk("model_kat_dec", ref_des(k1, c1, 1'b1), p1);
        chk("model_kat_zero", ref_des(z, z, 1'b0), c0);

        do_job(k1, p1, 1'b0, 2);
        do_job(k1, c1, 1'b1, 0);
        do_job(z, z, 1'b0, 1);
        aux_kat(k1, p1, 1'b0, c1);
        aux_kat(k1, c1, 1'b1, p1);
        aux_kat(z, z, 1'b0, c0);

        // Long stall in DONE with a pending request that must not be taken early.
        in_valid = 1'b1; in_key = k1; in_block = p1; in_decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk("stall_result", out_block, c1);
        held = out_block;
        in_valid = 1'b1; in_key = z; in_block = z; in_decrypt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_block", out_block, held);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_release_ready", 64'(in_ready), 64'd1);
        chk("stall_release_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_next_busy", 64'(busy), 64'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk("stall_next_latency", 64'(lat), 64'(LAT));
        chk("stall_next_result", out_block, c0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a job.
        in_valid = 1'b1; in_key = k1; in_block = p1; in_decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_block", out_block, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_rel_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("midrst_rel_ready_high", 64'(in_ready), 64'd1);
        chk("midrst_rel_valid", 64'(out_valid), 64'd0);
        do_job(k1, p1, 1'b0, 0);

        for (int j = 0; j < 1000; j++)
            do_job({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
